// File: rtl/packet_alu.sv
`default_nettype none
// packet_alu: parses framed echo/add/multiply command packets from an AXI-Stream byte
// source and streams little-endian results to an AXI-Stream byte sink.
// Revision: 1.0
module packet_alu #(
  parameter int OpWidth       = 32,
  parameter int TimeoutCycles = 100000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       error_o,
  output logic       busy_o
);
  localparam int NB = OpWidth / 8;

  typedef enum logic [3:0] {
    IDLE, RSVD, LEN_LO, LEN_HI, ECHO, OPERAND, MUL_BUSY, RESULT, DRAIN
  } state_t;

  state_t               state;
  logic                 is_echo, is_mul, have_acc;
  logic [7:0]           len_lo;
  logic [15:0]          remaining;
  logic [OpWidth-1:0]   acc, opnd, mcand, mplr, prod;
  logic [3:0]           byte_cnt, res_cnt;
  logic [6:0]           mul_cnt;
  logic [31:0]          tcount;
  logic [7:0]           out_data;
  logic                 out_valid, error;

  logic                 accept, timed, timeout_hit, op_last;
  logic [15:0]          len_w, pay_w;
  logic [OpWidth-1:0]   opnd_w, prod_step;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign len_w     = {s_axis_tdata, len_lo};
  assign pay_w     = len_w - 16'd4;
  // Operand bytes arrive little-endian; each lands at its byte lane.
  assign opnd_w    = opnd | (OpWidth'(s_axis_tdata) << {byte_cnt, 3'b000});
  assign op_last   = (byte_cnt == 4'(NB - 1));
  assign prod_step = mplr[0] ? prod + mcand : prod;

  assign timed = (state == RSVD) || (state == LEN_LO) || (state == LEN_HI) ||
                 (state == ECHO) || (state == OPERAND) || (state == DRAIN);
  assign timeout_hit = (TimeoutCycles != 0) && timed && s_axis_tready && !accept &&
                       (tcount == 32'(TimeoutCycles - 1));

  always_comb begin
    s_axis_tready = 1'b1;
    case (state)
      MUL_BUSY, RESULT: s_axis_tready = 1'b0;
      ECHO:             s_axis_tready = !(out_valid && !m_axis_tready);
      default:          s_axis_tready = 1'b1;
    endcase
    if (reset_i) s_axis_tready = 1'b0;
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign error_o       = error;
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      is_echo   <= 1'b0;
      is_mul    <= 1'b0;
      have_acc  <= 1'b0;
      len_lo    <= '0;
      remaining <= '0;
      acc       <= '0;
      opnd      <= '0;
      mcand     <= '0;
      mplr      <= '0;
      prod      <= '0;
      byte_cnt  <= '0;
      res_cnt   <= '0;
      mul_cnt   <= '0;
      tcount    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      if (m_axis_tready) out_valid <= 1'b0;
      if (accept) tcount <= '0;
      else if (timed && s_axis_tready) tcount <= tcount + 32'd1;

      if (timeout_hit) begin
        state    <= IDLE;
        error    <= 1'b1;
        tcount   <= '0;
        byte_cnt <= '0;
        opnd     <= '0;
      end else begin
        case (state)
          IDLE: if (accept && (s_axis_tdata == 8'hEC || s_axis_tdata == 8'hA0 ||
                               s_axis_tdata == 8'hB0)) begin
            is_echo <= (s_axis_tdata == 8'hEC);
            is_mul  <= (s_axis_tdata == 8'hB0);
            state   <= RSVD;
          end
          RSVD: if (accept) state <= LEN_LO;
          LEN_LO: if (accept) begin
            len_lo <= s_axis_tdata;
            state  <= LEN_HI;
          end
          LEN_HI: if (accept) begin
            remaining <= pay_w;
            byte_cnt  <= '0;
            opnd      <= '0;
            have_acc  <= 1'b0;
            if (len_w < 16'd4) begin
              error <= 1'b1;
              state <= IDLE;
            end else if (pay_w == 16'd0) begin
              error <= !is_echo;
              state <= IDLE;
            end else if (is_echo) begin
              state <= ECHO;
            end else if ((32'(pay_w) % NB) != 0) begin
              state <= DRAIN;
            end else begin
              state <= OPERAND;
            end
          end
          ECHO: if (accept) begin
            out_data  <= s_axis_tdata;
            out_valid <= 1'b1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= IDLE;
          end
          OPERAND: if (accept) begin
            remaining <= remaining - 16'd1;
            if (op_last) begin
              byte_cnt <= '0;
              opnd     <= '0;
              have_acc <= 1'b1;
              if (!have_acc) begin
                acc <= opnd_w;
                if (remaining == 16'd1) state <= RESULT;
              end else if (is_mul) begin
                mcand   <= acc;
                mplr    <= opnd_w;
                prod    <= '0;
                mul_cnt <= '0;
                state   <= MUL_BUSY;
              end else begin
                acc <= acc + opnd_w;
                if (remaining == 16'd1) state <= RESULT;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              opnd     <= opnd_w;
            end
          end
          MUL_BUSY: begin
            prod    <= prod_step;
            mcand   <= mcand << 1;
            mplr    <= mplr >> 1;
            mul_cnt <= mul_cnt + 7'd1;
            if (mul_cnt == 7'(OpWidth - 1)) begin
              acc   <= prod_step;
              state <= (remaining == 16'd0) ? RESULT : OPERAND;
            end
          end
          RESULT: if (!out_valid || m_axis_tready) begin
            out_data  <= acc[7:0];
            out_valid <= 1'b1;
            acc       <= acc >> 8;
            res_cnt   <= res_cnt + 4'd1;
            if (res_cnt == 4'(NB - 1)) begin
              res_cnt <= '0;
              state   <= IDLE;
            end
          end
          DRAIN: if (accept) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/packet_alu.md
# packet_alu

Byte-stream packet ALU sitting between the UART receiver and UART transmitter in the ALU wrapper. It parses framed command packets from an AXI-Stream byte source and executes echo, add or multiply over operands of parametrised width. It streams results to an AXI-Stream byte sink with full backpressure. Unlike the fixed echo-only path, it handles configurable operand width, multi-cycle multiplication, length validation and an inter-byte timeout that aborts stalled packets.

## Interface
- OpWidth, 32, operand/result width in bits; multiple of 8, 8..64
- TimeoutCycles, 100000, idle cycles allowed between accepted bytes inside a packet; 0 disables
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  received byte
- s_axis_tvalid  in  1  received byte valid
- s_axis_tready  out  1  block accepts byte
- m_axis_tdata  out  8  byte to transmit
- m_axis_tvalid  out  1  output byte valid
- m_axis_tready  in  1  sink accepts byte
- error_o  out  1  one-cycle pulse on packet abort
- busy_o  out  1  high whenever state != IDLE

## Operation
- Packet format: opcode, reserved (ignored), len_lo, len_hi, then payload. len is the 16-bit total byte count including the 4 header bytes. Payload length is P = len-4.
- Opcodes: 0xEC echo, 0xA0 add, 0xB0 multiply. Any other byte received in IDLE is discarded silently and the block stays in IDLE.
- States: IDLE, RSVD, LEN_LO, LEN_HI, ECHO, OPERAND, MUL_BUSY, RESULT, DRAIN.
- IDLE -> RSVD on a valid opcode. RSVD -> LEN_LO -> LEN_HI, one accepted byte each.
- At LEN_HI acceptance:
  - len<4 -> IDLE, pulse error_o.
  - P==0 -> IDLE with no output for echo, or error_o for add/mul.
  - add/mul with P not a multiple of OpWidth/8 -> DRAIN.
  - Otherwise echo -> ECHO; add/mul -> OPERAND.
- ECHO: each payload byte is forwarded unchanged. After P bytes -> IDLE.
- OPERAND: bytes assemble a little-endian operand.
  - First operand loads the accumulator.
  - add: each later operand is added mod 2^OpWidth as its last byte is accepted.
  - mul: each later operand enters MUL_BUSY, a shift-add over OpWidth cycles with the result truncated to OpWidth. It then returns to OPERAND.
  - After the final operand (and its multiply, if any) -> RESULT.
- RESULT: emits OpWidth/8 accumulator bytes, little-endian, then -> IDLE.
- DRAIN: consumes the remaining P bytes, then pulses error_o -> IDLE. No output.
- Timeout: in RSVD, LEN_LO, LEN_HI, ECHO, OPERAND or DRAIN, a counter tracks cycles since the last accepted byte.
  - When the count reaches TimeoutCycles: abort -> IDLE, pulse error_o, discard any partial operand.
  - A pending output byte still completes.
  - The counter is frozen in MUL_BUSY and RESULT, and while s_axis_tready is low.

## Timing
- Reset values: s_axis_tready=0 during reset and 1 in the first cycle after. m_axis_tvalid=0, m_axis_tdata=0, error_o=0, busy_o=0. State IDLE, accumulator 0, counters 0.
- Handshakes: a byte transfers when valid&&ready on a rising edge. m_axis_tvalid and m_axis_tdata stay stable until m_axis_tready.
- Output path is a single register.
- s_axis_tready rules:
  - Low in MUL_BUSY and RESULT.
  - Low in ECHO while the output register is full and m_axis_tready is low.
  - High otherwise, including IDLE.
- Echo latency: byte accepted at edge n is valid on m_axis from cycle n+1. Full throughput is 1 byte/cycle with sink ready.
- add: first result byte is valid 1 cycle after the last operand byte is accepted.
- mul: first result byte is valid OpWidth+1 cycles after the last operand byte is accepted.
- error_o is asserted for exactly 1 cycle, in the cycle after the triggering edge.
- Reset mid-packet: immediate return to reset values. Any pending output byte is dropped.
- len=0xFFFF is supported, using a 16-bit remaining counter with no wrap.

## Test plan
- Echo, sent twice (second instance with a 20-bit-time gap before the last byte): EC 00 06 00 48 69 -> output 48 69 each time, error_o never asserted.
- Garbage then echo: 00 48 EC 00 07 00 61 62 63 -> output exactly 61 62 63.
- Add wrap, OpWidth=32: A0 00 0C 00 01 00 00 00 FF FF FF FF -> output 00 00 00 00.
- Multiply, OpWidth=32: B0 00 0C 00 03 00 00 00 05 00 00 00 -> s_axis_tready low for 32 cycles, then output 0F 00 00 00.
- Bad length and timeout:
  - A0 00 07 00 11 22 33 -> error_o pulse after the last byte, no output.
  - With TimeoutCycles=50: EC 00 06 00 48 then silence -> 48 output, error_o at 50 idle cycles. A following echo packet then works normally.
- Backpressure: m_axis_tready low for 20 cycles during EC 00 07 00 AA BB CC -> s_axis_tready drops, output AA BB CC with no loss or duplication.
